// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO commit pipeline.
// Stage entries carry MAX_WIDTH data; the top slices to WIDTH.
package hilo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 3;
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 hi_v;
        logic [MAX_WIDTH-1:0] hi_d;
        logic                 lo_v;
        logic [MAX_WIDTH-1:0] lo_d;
    } hilo_entry_t;

    function automatic hilo_entry_t kill(input hilo_entry_t e);
        hilo_entry_t r;
        r      = e;
        r.hi_v = 1'b0;
        r.lo_v = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/hilo_stage.sv
// One HI/LO pipeline slot: load on advance, hold on stall,
// drop both valid bits on flush.
module hilo_stage
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  hilo_entry_t d,
    output hilo_entry_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= kill(q);
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO register file with a DEPTH-edge commit latency,
// stall/flush control and optional youngest-write forwarding.
module hilo_pipe
    import hilo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_arch_o,
    output logic [WIDTH-1:0] lo_arch_o,
    output logic             busy
);

    localparam int NST = (DEPTH > 1) ? DEPTH - 1 : 1;

    logic                 advance;
    hilo_entry_t          in_e;
    hilo_entry_t          cm;
    hilo_entry_t          stg [NST];
    logic [MAX_WIDTH-1:0] hi_arch;
    logic [MAX_WIDTH-1:0] lo_arch;
    logic [MAX_WIDTH-1:0] hi_fwd;
    logic [MAX_WIDTH-1:0] lo_fwd;
    logic                 busy_any;

    assign advance = !stall && !flush;

    always_comb begin
        in_e      = '0;
        in_e.hi_v = hi_we;
        in_e.hi_d = MAX_WIDTH'(hi_i);
        in_e.lo_v = lo_we;
        in_e.lo_d = MAX_WIDTH'(lo_i);
    end

    // stg[0] is p[1] (youngest); stg[NST-1] feeds the commit
    generate
        if (DEPTH > 1) begin : g_pipe
            for (genvar k = 0; k < NST; k++) begin : g_stg
                hilo_entry_t d;
                if (k == 0) begin : g_head
                    assign d = in_e;
                end else begin : g_tail
                    assign d = stg[k-1];
                end
                hilo_stage u_stage (
                    .clk   (clk),
                    .rst   (rst),
                    .load  (advance),
                    .clear (flush),
                    .d     (d),
                    .q     (stg[k])
                );
            end
            assign cm = stg[NST-1];
        end else begin : g_none
            assign stg[0] = '0;
            assign cm     = in_e;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_arch <= '0;
            lo_arch <= '0;
        end else if (advance) begin
            if (cm.hi_v) hi_arch <= cm.hi_d;
            if (cm.lo_v) lo_arch <= cm.lo_d;
        end
    end

    // walk oldest to youngest so the youngest valid half wins
    always_comb begin
        hi_fwd   = hi_arch;
        lo_fwd   = lo_arch;
        busy_any = 1'b0;
        for (int k = NST - 1; k >= 0; k--) begin
            if (stg[k].hi_v) hi_fwd = stg[k].hi_d;
            if (stg[k].lo_v) lo_fwd = stg[k].lo_d;
            busy_any = busy_any | stg[k].hi_v | stg[k].lo_v;
        end
        if (!FWD_EN) begin
            hi_fwd = hi_arch;
            lo_fwd = lo_arch;
        end
    end

    assign hi_o      = hi_fwd[WIDTH-1:0];
    assign lo_o      = lo_fwd[WIDTH-1:0];
    assign hi_arch_o = hi_arch[WIDTH-1:0];
    assign lo_arch_o = lo_arch[WIDTH-1:0];
    assign busy      = busy_any;

    logic unused_hi_bits;
    assign unused_hi_bits = ^{hi_fwd, lo_fwd, hi_arch, lo_arch};

endmodule

// File: tb/tb_hilo_pipe.sv
// Scoreboard bench: DEPTH=3 forwarding instance plus a
// DEPTH=1 non-forwarding instance sharing the same stimulus.
module tb_hilo_pipe;

    localparam int W = 32;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] hi_i = '0;
    logic [W-1:0] lo_i = '0;

    logic [W-1:0] a_hi, a_lo, a_harch, a_larch;
    logic         a_busy;
    logic [W-1:0] b_hi, b_lo, b_harch, b_larch;
    logic         b_busy;

    hilo_pipe #(.WIDTH(W), .DEPTH(D), .FWD_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(a_hi), .lo_o(a_lo), .hi_arch_o(a_harch),
        .lo_arch_o(a_larch), .busy(a_busy)
    );

    hilo_pipe #(.WIDTH(W), .DEPTH(1), .FWD_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(b_hi), .lo_o(b_lo), .hi_arch_o(b_harch),
        .lo_arch_o(b_larch), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // pending write: edges still needed before it commits
    typedef struct {
        logic         hv;
        logic [W-1:0] hd;
        logic         lv;
        logic [W-1:0] ld;
        int           left;
    } wr_t;

    typedef struct {
        logic [W-1:0] a_hi, a_lo, a_harch, a_larch;
        logic         a_busy;
        logic [W-1:0] b_arch_hi, b_arch_lo;
    } exp_t;

    wr_t          pend[$];
    exp_t         sb[$];
    logic [W-1:0] m_hi = '0, m_lo = '0, mb_hi = '0, mb_lo = '0;
    int           checks = 0;
    int           passed = 0;
    bit           done = 1'b0;

    task automatic chk(input string n, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    endtask

    // reference model: commits after DEPTH edges of progress
    always @(posedge clk) begin : model
        exp_t e;
        wr_t  w;
        if (rst) begin
            pend.delete();
            m_hi = '0; m_lo = '0; mb_hi = '0; mb_lo = '0;
        end else if (flush) begin
            pend.delete();
        end else if (!stall) begin
            for (int i = 0; i < pend.size(); i++)
                pend[i].left = pend[i].left - 1;
            while (pend.size() > 0 && pend[0].left == 0) begin
                w = pend.pop_front();
                if (w.hv) m_hi = w.hd;
                if (w.lv) m_lo = w.ld;
            end
            if (hi_we || lo_we)
                pend.push_back('{hi_we, hi_i, lo_we, lo_i, D - 1});
            if (hi_we) mb_hi = hi_i;
            if (lo_we) mb_lo = lo_i;
        end
        e.a_hi = m_hi;
        e.a_lo = m_lo;
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].hv) e.a_hi = pend[i].hd;
            if (pend[i].lv) e.a_lo = pend[i].ld;
        end
        e.a_harch   = m_hi;
        e.a_larch   = m_lo;
        e.a_busy    = (pend.size() != 0);
        e.b_arch_hi = mb_hi;
        e.b_arch_lo = mb_lo;
        sb.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("a_hi_o", a_hi, e.a_hi);
            chk("a_lo_o", a_lo, e.a_lo);
            chk("a_hi_arch", a_harch, e.a_harch);
            chk("a_lo_arch", a_larch, e.a_larch);
            chk("a_busy", 32'(a_busy), 32'(e.a_busy));
            chk("b_hi_o", b_hi, e.b_arch_hi);
            chk("b_lo_o", b_lo, e.b_arch_lo);
            chk("b_hi_arch", b_harch, e.b_arch_hi);
            chk("b_lo_arch", b_larch, e.b_arch_lo);
            chk("b_busy", 32'(b_busy), 32'd0);
        end
    end

    task automatic set_in(input logic hw, input logic [W-1:0] hd,
                          input logic lw, input logic [W-1:0] ld,
                          input logic st, input logic fl);
        hi_we = hw; hi_i = hd; lo_we = lw; lo_i = ld;
        stall = st; flush = fl;
    endtask

    task automatic idle();
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1;
        chk("rst_hi_o", a_hi, '0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        step(); step();
        rst = 1'b0;

        // single HI write, arch LO untouched
        set_in(1'b1, 32'h1111_1111, 1'b0, '0, 1'b0, 1'b0);
        step(); idle();
        chk("d29_hi_o_c1", a_hi, 32'h1111_1111);
        chk("d29_arch_c1", a_harch, 32'h0);
        step();
        chk("d29_arch_c2", a_harch, 32'h0);
        step();
        chk("d29_arch_c3", a_harch, 32'h1111_1111);
        chk("d29_lo_arch", a_larch, 32'h0);
        step();

        // back-to-back HI writes
        set_in(1'b1, 32'hA, 1'b0, '0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'hB, 1'b0, '0, 1'b0, 1'b0);
        step(); idle();
        chk("d30_hi_o_c2", a_hi, 32'hB);
        step();
        chk("d30_arch_c3", a_harch, 32'hA);
        step();
        chk("d30_arch_c4", a_harch, 32'hB);
        step();

        // LO write delayed by two stall cycles
        set_in(1'b0, '0, 1'b1, 32'h55, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'hDEAD, 1'b1, 32'hBEEF, 1'b1, 1'b0);
        step(); step(); idle();
        step();
        chk("d31_lo_c4", a_larch, 32'h0);
        step();
        chk("d31_lo_c5", a_larch, 32'h55);
        step();

        // flush beats stall
        set_in(1'b1, 32'h77, 1'b0, '0, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        step(); idle();
        chk("d32_hi_o_c2", a_hi, 32'hB);
        chk("d32_busy_c2", 32'(a_busy), 32'd0);
        step(); step(); step();
        chk("d32_arch", a_harch, 32'hB);

        // async reset with two writes in flight
        set_in(1'b1, 32'hC1, 1'b0, '0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'hC3, 1'b1, 32'hC2, 1'b0, 1'b0);
        step(); idle();
        #1 rst = 1'b1;
        #1;
        chk("d33_hi_o", a_hi, '0);
        chk("d33_lo_o", a_lo, '0);
        chk("d33_hi_arch", a_harch, '0);
        chk("d33_busy", 32'(a_busy), 32'd0);
        chk("d33_b_hi", b_hi, '0);
        step();
        rst = 1'b0;
        step(); step(); step(); step();
        chk("d33_after_hi", a_harch, '0);
        chk("d33_after_lo", a_larch, '0);

        // single-stage non-forwarding instance
        set_in(1'b1, 32'd3, 1'b1, 32'd4, 1'b0, 1'b0);
        step(); idle();
        chk("d34_hi_o", b_hi, 32'd3);
        chk("d34_lo_o", b_lo, 32'd4);
        chk("d34_busy", 32'(b_busy), 32'd0);
        step();

        for (int n = 0; n < 2000; n++) begin
            set_in($urandom_range(0, 1) == 1, $urandom(),
                   $urandom_range(0, 1) == 1, $urandom(),
                   $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 5);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step(); step(); step(); step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hilo_pipe.md
HILO_PIPE -- requirements
Module: hilo_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width of HI and LO.
REQ-002 SHALL have parameter DEPTH, default 3, legal 1..4, giving the commit latency in clock edges.
REQ-003 SHALL have parameter FWD_EN, default 1, which enables forwarding of in-flight writes to hi_o/lo_o.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1 bit: freezes the pipeline; no capture and no commit.
REQ-007 SHALL have port flush, input, 1 bit: discards all uncommitted writes.
REQ-008 SHALL have ports hi_we and lo_we, input, 1 bit each: independent write requests.
REQ-009 SHALL have ports hi_i and lo_i, input, WIDTH bits each: write data.
REQ-010 SHALL have ports hi_o and lo_o, output, WIDTH bits each: forwarded (youngest) view.
REQ-011 SHALL have ports hi_arch_o and lo_arch_o, output, WIDTH bits each: committed architectural values.
REQ-012 SHALL have port busy, output, 1 bit: high when any pipeline stage holds a valid HI or LO write.

Function
REQ-013 SHALL implement DEPTH-1 pipeline stages p[1]..p[DEPTH-1] (p[1] youngest), each holding hi_v, hi_d, lo_v and lo_d, followed by the architectural registers.
REQ-014 SHALL, for DEPTH=1, have no pipeline stages: a write in cycle t SHALL appear on *_arch_o in cycle t+1.
REQ-015 SHALL, for DEPTH>1, make a write presented in cycle t with stall=0 and flush=0 visible on *_arch_o in cycle t+DEPTH, provided there is no intervening stall or flush.
REQ-016 SHALL, on an edge with stall=0 and flush=0:
- load p[1] from the inputs (hi_v=hi_we, lo_v=lo_we);
- shift p[k] into p[k+1];
- commit each valid half of p[DEPTH-1] to its architectural register.
REQ-017 SHALL track the HI and LO halves independently; an invalid half SHALL leave the corresponding architectural register unchanged.
REQ-018 SHALL, on an edge with stall=1 and flush=0, hold all stages and architectural registers and ignore hi_we/lo_we.
REQ-019 SHALL, on an edge with flush=1, clear every stage valid bit, perform no commit, and discard the current inputs; flush SHALL take priority over stall.
REQ-020 SHALL, with FWD_EN=1, drive hi_o from the youngest stage whose hi_v=1 (p[1] has highest priority), else from hi_arch_o; lo_o SHALL be driven likewise and independently.
REQ-021 SHALL NOT forward the current-cycle inputs combinationally to hi_o/lo_o.
REQ-022 SHALL, with FWD_EN=0, drive hi_o=hi_arch_o and lo_o=lo_arch_o.
REQ-023 SHALL drive busy as the OR of all stage valid bits; busy SHALL be constant 0 when DEPTH=1.
REQ-024 SHALL allow back-to-back writes every cycle with no bubbles; the last write to reach commit wins.

Reset
REQ-025 SHALL, while rst=1, immediately clear all stage valid bits and stage data, set hi_arch_o=lo_arch_o=0, and therefore drive hi_o=lo_o=0 and busy=0.
REQ-026 SHALL give rst priority over flush, stall and writes, including reset asserted mid-pipeline; in-flight writes SHALL be lost.

Structure
REQ-027 SHALL place the stage-entry typedef (hi_v, hi_d, lo_v, lo_d) and the default WIDTH/DEPTH constants in shared package hilo_pkg.
REQ-028 SHALL implement one pipeline stage as sub-module hilo_stage (load, hold, clear), instantiated DEPTH-1 times with a generate loop.

Verification
REQ-029 SHALL cover, with DEPTH=3: hi_we=1, hi_i=0x1111_1111 in cycle 0 -> hi_o=0x1111_1111 from cycle 1, hi_arch_o from cycle 3, lo_arch_o stays 0.
REQ-030 SHALL cover: write hi=0xA in cycle 0, then hi=0xB in cycle 1 -> hi_o=0xB from cycle 2, hi_arch_o=0xA in cycle 3 and 0xB from cycle 4.
REQ-031 SHALL cover: write lo=0x55 in cycle 0, stall=1 in cycles 1-2 -> lo_arch_o stays 0 through cycle 4 and becomes 0x55 in cycle 5.
REQ-032 SHALL cover: write hi=0x77 in cycle 0, flush=1 with stall=1 in cycle 1 -> hi_arch_o is never 0x77, hi_o returns to the old architectural value in cycle 2, and busy=0 in cycle 2.
REQ-033 SHALL cover: rst asserted asynchronously mid-cycle with two writes in flight -> all outputs 0 immediately; after release, the old writes never commit.
REQ-034 SHALL cover: DEPTH=1, FWD_EN=0, hi_we=lo_we=1 with hi_i=3, lo_i=4 -> hi_o=3 and lo_o=4 in the next cycle, busy=0 throughout.
